handwrite_canvas: RTL and testbench

Upstream stage of the scroll display: it turns pen samples into the 30×30 handwriting bitmap that the display draws live. It detects the end of a stroke group by an idle timeout and sends the frozen bitmap to the digit classifier over a req/ack handshake. It then presents the recognised digit to the scroll stage with a single-cycle identified pulse and clears the canvas for the next answer.

---
 rtl/handwrite_canvas.sv | 135 +++++++++++++
 tb/tb_handwrite_canvas.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/handwrite_canvas.sv
// Pen-sample canvas: paints a 30x30 bitmap, submits it to the digit classifier
// after an idle timeout, then reports the accepted digit and clears the canvas.
module handwrite_canvas #(
  parameter int IDLE_CYCLES = 12_500_000,
  parameter int BRUSH       = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_pen_valid,
  input  logic         i_pen_down,
  input  logic [4:0]   i_pen_x,
  input  logic [4:0]   i_pen_y,
  input  logic         i_clear,
  output logic [899:0] o_handwrite,
  output logic         o_cls_req,
  input  logic         i_cls_ack,
  input  logic [3:0]   i_cls_digit,
  output logic [3:0]   o_digit_answered,
  output logic         o_digit_identified,
  output logic         o_busy,
  output logic [1:0]   state_dbg
);

  localparam int CNT_W = $clog2(IDLE_CYCLES);
  // The counter reads 0 in the cycle after a paint, so it holds IDLE_CYCLES-2
  // in the cycle that must trigger the move to S_CLASSIFY.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_DRAW     = 2'd1,
    S_CLASSIFY = 2'd2,
    S_REPORT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             paint_sample;
  logic             do_paint, do_wipe, pulse_d;
  logic [899:0]     paint_mask;
  int               px, py;
  logic [9:0]       idx;

  assign state_dbg = state_q;

  assign paint_sample = i_pen_valid && i_pen_down &&
                        (i_pen_x <= 5'd29) && (i_pen_y <= 5'd29);

  // Brush footprint, clipped to the canvas on both axes.
  always_comb begin
    paint_mask = '0;
    px  = 0;
    py  = 0;
    idx = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        px = int'(i_pen_x) + dx;
        py = int'(i_pen_y) + dy;
        if ((BRUSH != 0 || (dx == 0 && dy == 0)) &&
            px >= 0 && px <= 29 && py >= 0 && py <= 29) begin
          idx = 10'(py * 30 + px);
          paint_mask[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_paint = 1'b0;
    do_wipe  = 1'b0;
    pulse_d  = 1'b0;
    if (i_clear) begin
      state_d = S_EMPTY;
      cnt_d   = '0;
      do_wipe = 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (paint_sample) begin
            do_paint = 1'b1;
            cnt_d    = '0;
            state_d  = S_DRAW;
          end
        end
        S_DRAW: begin
          if (paint_sample) begin
            do_paint = 1'b1;
            cnt_d    = '0;
          end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          // Result is applied on entry to S_REPORT so the pulse lands in M+1.
          if (i_cls_ack) begin
            state_d = S_REPORT;
            do_wipe = 1'b1;
            pulse_d = (i_cls_digit <= 4'd9);
          end
        end
        S_REPORT: begin
          state_d = S_EMPTY;
          cnt_d   = '0;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q            <= S_EMPTY;
      cnt_q              <= '0;
      o_handwrite        <= '0;
      o_cls_req          <= 1'b0;
      o_busy             <= 1'b0;
      o_digit_identified <= 1'b0;
      o_digit_answered   <= 4'hf;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      o_cls_req          <= (state_d == S_CLASSIFY);
      o_busy             <= (state_d == S_CLASSIFY) || (state_d == S_REPORT);
      o_digit_identified <= pulse_d;
      if (pulse_d) o_digit_answered <= i_cls_digit;
      if (do_wipe)       o_handwrite <= '0;
      else if (do_paint) o_handwrite <= o_handwrite | paint_mask;
    end
  end

endmodule

// File: tb/tb_handwrite_canvas.sv
// Directed bench for handwrite_canvas: brush table, idle timeout, classifier
// handshake, reject, clear priority and reset.
module tb_handwrite_canvas;

  logic         clk;
  logic         rst_n;
  logic         pen_valid, pen_down;
  logic [4:0]   pen_x, pen_y;
  logic         clear;
  logic [899:0] handwrite;
  logic         cls_req;
  logic         cls_ack;
  logic [3:0]   cls_digit;
  logic [3:0]   digit_answered;
  logic         digit_identified;
  logic         busy;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  handwrite_canvas #(.IDLE_CYCLES(8), .BRUSH(1)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_pen_valid        (pen_valid),
    .i_pen_down         (pen_down),
    .i_pen_x            (pen_x),
    .i_pen_y            (pen_y),
    .i_clear            (clear),
    .o_handwrite        (handwrite),
    .o_cls_req          (cls_req),
    .i_cls_ack          (cls_ack),
    .i_cls_digit        (cls_digit),
    .o_digit_answered   (digit_answered),
    .o_digit_identified (digit_identified),
    .o_busy             (busy),
    .state_dbg          (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic pen(input logic v, input logic d, input logic [4:0] x, input logic [4:0] y);
    pen_valid = v;
    pen_down  = d;
    pen_x     = x;
    pen_y     = y;
  endtask

  task automatic run_to_req(input logic [4:0] x, input logic [4:0] y);
    pen(1'b1, 1'b1, x, y);
    tick();
    pen(1'b0, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 20; i++) begin
      if (cls_req) break;
      tick();
    end
    check("req_rise", cls_req, 1);
  endtask

  // Scoreboard: every identified pulse must match the next expected digit.
  always @(negedge clk) begin
    if (rst_n && digit_identified) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", digit_identified, 0);
      end else begin
        check("pulse_digit", digit_answered, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic       v;
    logic       d;
    logic [4:0] x;
    logic [4:0] y;
    int         pop;
    int         bit_a;
    int         bit_b;
    int         bit_z;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // v, d, x, y, ink count after, two bits that must be set, one that must be clear
    tbl[0] = '{1'b1, 1'b1, 5'd0,  5'd0,  4,  1,   30,  2};
    tbl[1] = '{1'b1, 1'b1, 5'd15, 5'd10, 13, 284, 346, 347};
    tbl[2] = '{1'b1, 1'b1, 5'd30, 5'd5,  13, 0,   31,  149};
    tbl[3] = '{1'b1, 1'b0, 5'd5,  5'd5,  13, 315, 285, 155};
    tbl[4] = '{1'b0, 1'b1, 5'd5,  5'd5,  13, 0,   316, 155};
    tbl[5] = '{1'b1, 1'b1, 5'd29, 5'd29, 17, 899, 868, 867};
    tbl[6] = '{1'b1, 1'b1, 5'd1,  5'd1,  22, 62,  2,   63};
    tbl[7] = '{1'b1, 1'b1, 5'd5,  5'd31, 22, 62,  0,   875};

    rst_n = 1'b0;
    pen(1'b0, 1'b0, 5'd0, 5'd0);
    clear     = 1'b0;
    cls_ack   = 1'b0;
    cls_digit = 4'd0;
    tick();
    tick();
    check("rst_handwrite", $countones(handwrite), 0);
    check("rst_req", cls_req, 0);
    check("rst_answered", digit_answered, 4'hf);
    check("rst_identified", digit_identified, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    tick();

    // Brush / clipping table
    for (int i = 0; i < 8; i++) begin
      pen(tbl[i].v, tbl[i].d, tbl[i].x, tbl[i].y);
      tick();
      check($sformatf("tbl%0d_pop", i), $countones(handwrite), tbl[i].pop);
      check($sformatf("tbl%0d_a", i), handwrite[tbl[i].bit_a], 1);
      check($sformatf("tbl%0d_b", i), handwrite[tbl[i].bit_b], 1);
      check($sformatf("tbl%0d_z", i), handwrite[tbl[i].bit_z], 0);
    end
    pen(1'b0, 1'b0, 5'd0, 5'd0);
    check("draw_state", state_dbg, 1);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_pop", $countones(handwrite), 0);
    check("clear_state", state_dbg, 0);

    // Timeout: paint at N, re-paint at N+6, request rises at N+14
    pen(1'b1, 1'b1, 5'd3, 5'd3);
    tick();                                   // N+1
    pen(1'b0, 1'b0, 5'd0, 5'd0);
    check("paint_visible", $countones(handwrite), 9);
    for (int i = 0; i < 5; i++) tick();       // N+6
    pen(1'b1, 1'b1, 5'd20, 5'd20);
    tick();                                   // N+7
    pen(1'b0, 1'b0, 5'd0, 5'd0);
    check("req_n7", cls_req, 0);
    tick();                                   // N+8
    check("req_n8_moved", cls_req, 0);
    for (int i = 0; i < 5; i++) tick();       // N+13
    check("req_n13", cls_req, 0);
    check("busy_n13", busy, 0);
    tick();                                   // N+14
    check("req_n14", cls_req, 1);
    check("busy_n14", busy, 1);
    check("classify_state", state_dbg, 2);

    // Pen is ignored while the bitmap is frozen
    pen(1'b1, 1'b1, 5'd25, 5'd0);
    tick();                                   // N+15
    pen(1'b0, 1'b0, 5'd0, 5'd0);
    check("frozen_pop", $countones(handwrite), 18);
    check("frozen_bit", handwrite[25], 0);
    tick();                                   // N+16, third request cycle

    // Ack held for two cycles still gives a single pulse
    cls_ack   = 1'b1;
    cls_digit = 4'd7;
    exp_q.push_back(4'd7);
    tick();                                   // M+1
    check("ack_identified", digit_identified, 1);
    check("ack_answered", digit_answered, 7);
    check("ack_req_drop", cls_req, 0);
    check("ack_pop", $countones(handwrite), 0);
    check("ack_busy_m1", busy, 1);
    tick();                                   // M+2
    cls_ack = 1'b0;
    check("ack_pulse_end", digit_identified, 0);
    check("ack_busy_m2", busy, 0);
    check("ack_state_m2", state_dbg, 0);
    check("ack_hold", digit_answered, 7);

    // Accepted 3, then reject 12
    run_to_req(5'd10, 5'd10);
    cls_ack   = 1'b1;
    cls_digit = 4'd3;
    exp_q.push_back(4'd3);
    tick();
    cls_ack = 1'b0;
    check("digit3", digit_answered, 3);
    tick();
    run_to_req(5'd12, 5'd12);
    cls_ack   = 1'b1;
    cls_digit = 4'd12;
    tick();
    cls_ack = 1'b0;
    check("reject_no_pulse", digit_identified, 0);
    check("reject_answered", digit_answered, 3);
    check("reject_pop", $countones(handwrite), 0);
    tick();
    check("reject_state", state_dbg, 0);

    // Clear beats ack in the same cycle
    run_to_req(5'd4, 5'd4);
    clear     = 1'b1;
    cls_ack   = 1'b1;
    cls_digit = 4'd5;
    tick();
    clear   = 1'b0;
    cls_ack = 1'b0;
    check("prio_no_pulse", digit_identified, 0);
    check("prio_answered", digit_answered, 3);
    check("prio_state", state_dbg, 0);
    check("prio_req", cls_req, 0);
    check("prio_busy", busy, 0);
    check("prio_pop", $countones(handwrite), 0);

    // Ack while drawing is ignored
    pen(1'b1, 1'b1, 5'd8, 5'd8);
    tick();
    pen(1'b0, 1'b0, 5'd0, 5'd0);
    cls_ack   = 1'b1;
    cls_digit = 4'd9;
    tick();
    cls_ack = 1'b0;
    check("draw_ack_state", state_dbg, 1);
    check("draw_ack_answered", digit_answered, 3);
    check("draw_ack_pop", $countones(handwrite), 9);
    check("draw_ack_req", cls_req, 0);

    // Reset in the middle of S_CLASSIFY
    run_to_req(5'd6, 5'd6);
    rst_n = 1'b0;
    tick();
    check("midrst_req", cls_req, 0);
    check("midrst_pop", $countones(handwrite), 0);
    check("midrst_answered", digit_answered, 4'hf);
    check("midrst_busy", busy, 0);
    check("midrst_state", state_dbg, 0);
    rst_n = 1'b1;
    tick();
    tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
